// File: rtl/red_pitaya_daisy_pkg.sv
// Shared encodings for the daisy-chain transmit controller: FSM states,
// source-select modes, requester indices and a saturating counter helper.
package red_pitaya_daisy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } daisy_state_e;

  typedef enum logic [1:0] {
    MODE_TST  = 2'd0,
    MODE_USR  = 2'd1,
    MODE_RR   = 2'd2,
    MODE_NONE = 2'd3
  } daisy_mode_e;

  localparam int REQ_TST = 0;
  localparam int REQ_USR = 1;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/red_pitaya_daisy_tx_ctrl_if.sv
// Source and serializer handshakes of the daisy transmit controller.
// slave = controller side, master = the agents driving sources / serializer.
interface red_pitaya_daisy_tx_ctrl_if;
  logic        tst_dv_i;
  logic [15:0] tst_dat_i;
  logic        tst_rdy_o;
  logic        usr_dv_i;
  logic [15:0] usr_dat_i;
  logic        usr_rdy_o;
  logic        ser_rdy_i;
  logic        ser_dv_o;
  logic [15:0] ser_dat_o;

  modport slave (
    input  tst_dv_i, tst_dat_i, usr_dv_i, usr_dat_i, ser_rdy_i,
    output tst_rdy_o, usr_rdy_o, ser_dv_o, ser_dat_o
  );

  modport master (
    output tst_dv_i, tst_dat_i, usr_dv_i, usr_dat_i, ser_rdy_i,
    input  tst_rdy_o, usr_rdy_o, ser_dv_o, ser_dat_o
  );
endinterface

// File: rtl/red_pitaya_daisy_rr_arb.sv
// Two-requester grant logic: fixed modes plus round-robin that alternates
// only on contention, pointer advancing on completed transfers.
module red_pitaya_daisy_rr_arb
  import red_pitaya_daisy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       xfer,
  input  logic [1:0] mode,
  output logic [1:0] gnt
);

  logic last_usr_q;

  always_comb begin
    gnt = 2'b00;
    case (daisy_mode_e'(mode))
      MODE_TST: gnt[REQ_TST] = 1'b1;
      MODE_USR: gnt[REQ_USR] = 1'b1;
      MODE_RR: begin
        if (req[REQ_TST] && req[REQ_USR]) begin
          if (last_usr_q) gnt[REQ_TST] = 1'b1;
          else            gnt[REQ_USR] = 1'b1;
        end else begin
          gnt = req;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  // Reset to "user last" so the test source wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_usr_q <= 1'b1;
    else if (xfer) last_usr_q <= gnt[REQ_USR];
  end

endmodule

// File: rtl/red_pitaya_daisy_tx_ctrl.sv
// Daisy-chain transmit controller: link training, then arbitrated forwarding
// of test/user words to the serializer with a 1-cycle registered output.
module red_pitaya_daisy_tx_ctrl
  import red_pitaya_daisy_pkg::*;
#(
  parameter int          TRAIN_LEN = 256,
  parameter logic [15:0] TRAIN_PAT = 16'h00FF
) (
  input  logic       tx_clk_i,
  input  logic       tx_rstn_i,
  input  logic       cfg_en_i,
  input  logic       cfg_train_i,
  input  logic [1:0] cfg_mode_i,
  input  logic       stat_clr_i,
  output logic [1:0] sts_state_o,
  output logic [31:0] sts_cnt_o,
  red_pitaya_daisy_tx_ctrl_if.slave bus
);

  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);

  daisy_state_e state_q, state_d;
  logic [15:0]  train_cnt_q;
  logic         train_beat;
  logic         run_ok;
  logic [1:0]   req, gnt, xfer_vec;
  logic         xfer;
  logic [15:0]  src_dat;

  always_ff @(posedge tx_clk_i or negedge tx_rstn_i) begin
    if (!tx_rstn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Disable overrides everything, including a training beat or grant.
  always_comb begin
    state_d    = state_q;
    train_beat = 1'b0;
    run_ok     = 1'b0;
    case (state_q)
      ST_IDLE:  if (cfg_en_i) state_d = ST_TRAIN;
      ST_TRAIN: begin
        if (bus.ser_rdy_i) begin
          train_beat = 1'b1;
          if (train_cnt_q == TRAIN_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_train_i) state_d = ST_TRAIN;
        else             run_ok  = bus.ser_rdy_i;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d    = ST_IDLE;
      train_beat = 1'b0;
      run_ok     = 1'b0;
    end
  end

  assign req = {bus.usr_dv_i, bus.tst_dv_i};

  red_pitaya_daisy_rr_arb u_arb (
    .clk   (tx_clk_i),
    .rst_n (tx_rstn_i),
    .req   (req),
    .xfer  (xfer),
    .mode  (cfg_mode_i),
    .gnt   (gnt)
  );

  assign bus.tst_rdy_o = run_ok & gnt[REQ_TST];
  assign bus.usr_rdy_o = run_ok & gnt[REQ_USR];
  assign xfer_vec      = req & {bus.usr_rdy_o, bus.tst_rdy_o};
  assign xfer          = |xfer_vec;
  assign src_dat       = xfer_vec[REQ_TST] ? bus.tst_dat_i : bus.usr_dat_i;

  // Counter is held at zero outside TRAIN so every entry starts fresh.
  always_ff @(posedge tx_clk_i or negedge tx_rstn_i) begin
    if (!tx_rstn_i)               train_cnt_q <= '0;
    else if (state_d != ST_TRAIN) train_cnt_q <= '0;
    else if (train_beat)          train_cnt_q <= train_cnt_q + 16'd1;
  end

  always_ff @(posedge tx_clk_i or negedge tx_rstn_i) begin
    if (!tx_rstn_i) begin
      bus.ser_dv_o  <= 1'b0;
      bus.ser_dat_o <= '0;
    end else begin
      bus.ser_dv_o <= train_beat | xfer;
      if (train_beat) bus.ser_dat_o <= TRAIN_PAT;
      else if (xfer)  bus.ser_dat_o <= src_dat;
    end
  end

  always_ff @(posedge tx_clk_i or negedge tx_rstn_i) begin
    if (!tx_rstn_i)      sts_cnt_o <= '0;
    else if (stat_clr_i) sts_cnt_o <= '0;
    else if (xfer)       sts_cnt_o <= sat_inc(sts_cnt_o);
  end

  assign sts_state_o = state_q;

endmodule

// File: doc/red_pitaya_daisy_tx_ctrl.md
RED_PITAYA_DAISY_TX_CTRL -- requirements
Module: red_pitaya_daisy_tx_ctrl

Interface
REQ-001 SHALL have parameter TRAIN_LEN, default 256: number of accepted training words per training phase (range 2..65535).
REQ-002 SHALL have parameter TRAIN_PAT, default 16'h00FF: training word sent during TRAIN.
REQ-003 SHALL have port tx_clk_i, in, 1: the single clock.
REQ-004 SHALL have port tx_rstn_i, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_en_i, in, 1: link enable, level.
REQ-006 SHALL have port cfg_train_i, in, 1: retrain request, single-cycle pulse.
REQ-007 SHALL have port cfg_mode_i, in, 2: 0 test only, 1 user only, 2 round-robin, 3 no grants.
REQ-008 SHALL have ports tst_dv_i in 1, tst_dat_i in 16, tst_rdy_o out 1: test-source handshake.
REQ-009 SHALL have ports usr_dv_i in 1, usr_dat_i in 16, usr_rdy_o out 1: user-source handshake.
REQ-010 SHALL have ports ser_rdy_i in 1, ser_dv_o out 1, ser_dat_o out 16: serial transmitter handshake; ser_rdy_i high in cycle N means the transmitter accepts a word presented in cycle N+1.
REQ-011 SHALL have ports stat_clr_i in 1, sts_state_o out 2, sts_cnt_o out 32: counter clear, FSM state, accepted-word count.

Function
REQ-012 FSM states SHALL be IDLE(0), TRAIN(1), RUN(2); encoding SHALL appear on sts_state_o.
REQ-013 IDLE -> TRAIN when cfg_en_i=1; any state -> IDLE when cfg_en_i=0, with priority over all other transitions.
REQ-014 In TRAIN, each cycle with ser_rdy_i=1 SHALL produce ser_dv_o=1 and ser_dat_o=TRAIN_PAT on the next cycle and SHALL increment a 16-bit training counter.
REQ-015 TRAIN -> RUN on the cycle the training counter reaches TRAIN_LEN-1 with ser_rdy_i=1; the counter SHALL clear on every entry to TRAIN.
REQ-016 RUN -> TRAIN when cfg_train_i=1; no source transfer SHALL be granted in that cycle.
REQ-017 tst_rdy_o/usr_rdy_o SHALL be combinational: high only in RUN, with ser_rdy_i=1, for the granted source.
REQ-018 Mode 0 SHALL grant test only, and mode 1 user only; mode 3 SHALL grant neither.
REQ-019 Mode 2: with only one dv high, that source is granted; with both high, the source not granted at the last transfer is granted. The last-grant pointer SHALL be updated only on transfer (dv & rdy) and SHALL reset to user, so test wins first.
REQ-020 A transfer in cycle N SHALL give ser_dv_o=1 and ser_dat_o = source data in cycle N+1 (latency 1, registered); otherwise ser_dv_o=0 and ser_dat_o holds its last value.
REQ-021 cfg_mode_i changes SHALL take effect in the same cycle; no word is lost or duplicated.
REQ-022 sts_cnt_o SHALL count RUN-state source transfers, saturating at 32'hFFFFFFFF; stat_clr_i SHALL clear it next cycle, and a simultaneous transfer SHALL be dropped in favour of the clear.
REQ-023 Training words SHALL NOT be counted in sts_cnt_o.

Reset
REQ-024 On tx_rstn_i=0, asynchronously: state IDLE, ser_dv_o 0, ser_dat_o 0, training counter 0, sts_cnt_o 0, last-grant user. tst_rdy_o/usr_rdy_o SHALL be 0 as a consequence.
REQ-025 Reset mid-TRAIN or mid-RUN SHALL abort without emitting further ser_dv_o; after release, training restarts from 0.

Structure
REQ-026 State encoding and mode encoding constants SHALL live in shared package red_pitaya_daisy_pkg.
REQ-027 Two-requester round-robin logic SHALL be sub-module red_pitaya_daisy_rr_arb (inputs req[1:0], xfer, mode; output gnt[1:0]).

Verification
REQ-028 Reset release, cfg_en_i=1, ser_rdy_i=1, TRAIN_LEN=4 -> four ser_dv_o pulses of 16'h00FF, then sts_state_o=2.
REQ-029 RUN, mode 2, both dv held, ser_rdy_i=1 -> ser_dat_o alternates tst/usr starting with tst; sts_cnt_o=10 after 10 cycles.
REQ-030 RUN, mode 2, only usr_dv_i=1 for 5 cycles -> 5 user words, tst_rdy_o stays 0; then both dv high -> test granted next.
REQ-031 RUN, cfg_train_i pulse with both dv high -> no grant that cycle, sts_state_o=1, TRAIN_LEN training words, then RUN.
REQ-032 ser_rdy_i=0 in RUN -> both rdy 0, ser_dv_o 0 next cycle; stat_clr_i coincident with a transfer -> sts_cnt_o=0.
REQ-033 cfg_en_i=0 mid-TRAIN at count 2, re-enable -> full TRAIN_LEN words before RUN; async reset mid-RUN -> ser_dv_o 0 immediately.
